// File: rtl/interrupt_controller_pkg.sv
// Shared constants for the interrupt path: FSM state encoding, push timing default
// and the pipeline opcodes the controller cooperates with.
package interrupt_controller_pkg;

    localparam int unsigned STATE_W      = 3;
    localparam int unsigned CNT_W        = 4;
    localparam int unsigned COUNT_W      = 8;
    localparam int unsigned PUSH_CYCLES_DEF = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_INJECT  = 3'd1,
        ST_PUSH    = 3'd2,
        ST_ISR     = 3'd3,
        ST_RESTORE = 3'd4
    } state_t;

    // Pipeline opcodes whose EXM presence affects when an interrupt may be taken
    localparam int unsigned OPCODE_W = 5;
    localparam logic [OPCODE_W-1:0] OP_NOP  = 5'h00;
    localparam logic [OPCODE_W-1:0] OP_JMP  = 5'h10;
    localparam logic [OPCODE_W-1:0] OP_CALL = 5'h11;
    localparam logic [OPCODE_W-1:0] OP_RET  = 5'h12;
    localparam logic [OPCODE_W-1:0] OP_RTI  = 5'h13;
    localparam logic [OPCODE_W-1:0] OP_PUSH = 5'h14;
    localparam logic [OPCODE_W-1:0] OP_POP  = 5'h15;

endpackage

// File: rtl/interrupt_controller_edge_latch.sv
// Rising-edge detector on the interrupt request feeding a depth-1 pending latch.
module int_edge_latch (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_int_req,
    input  logic i_clear,
    output logic o_pending
);

    logic req_q;

    // Set has priority so an edge arriving on the clearing cycle is not lost
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            req_q     <= 1'b0;
            o_pending <= 1'b0;
        end else begin
            req_q <= i_int_req;
            if (i_int_req && !req_q) begin
                o_pending <= 1'b1;
            end else if (i_clear) begin
                o_pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt sequencer: waits for a safe pipeline slot, injects the vector, reserves
// stack-push cycles, masks during the ISR and restores flags on RTI.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int unsigned PUSH_CYCLES = PUSH_CYCLES_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_int_req,
    input  logic               i_branch_decision,
    input  logic               i_push_pc,
    input  logic               i_pop_pc,
    input  logic               i_rti,
    output logic               o_interrupt,
    output logic               o_flush_f_d,
    output logic               o_save_flags,
    output logic               o_restore_flags,
    output logic               o_busy,
    output logic [COUNT_W-1:0] o_int_count
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pending;
    logic             safe_c;
    logic             take_c;

    assign safe_c = !i_branch_decision && !i_push_pc && !i_pop_pc;
    assign take_c = (state == ST_IDLE) && pending && safe_c;

    int_edge_latch u_latch (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_int_req (i_int_req),
        .i_clear   (take_c),
        .o_pending (pending)
    );

    // Outputs are registered alongside the state so they match the state being entered
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            o_int_count     <= '0;
            o_interrupt     <= 1'b0;
            o_flush_f_d     <= 1'b0;
            o_save_flags    <= 1'b0;
            o_restore_flags <= 1'b0;
            o_busy          <= 1'b0;
        end else begin
            o_interrupt     <= 1'b0;
            o_flush_f_d     <= 1'b0;
            o_save_flags    <= 1'b0;
            o_restore_flags <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (take_c) begin
                        state       <= ST_INJECT;
                        o_interrupt <= 1'b1;
                        o_flush_f_d <= 1'b1;
                        o_busy      <= 1'b1;
                    end else begin
                        o_busy <= 1'b0;
                    end
                end
                ST_INJECT: begin
                    state        <= ST_PUSH;
                    cnt          <= CNT_W'(PUSH_CYCLES - 1);
                    o_int_count  <= o_int_count + COUNT_W'(1);
                    o_save_flags <= 1'b1;
                    o_busy       <= 1'b1;
                end
                ST_PUSH: begin
                    o_busy <= 1'b1;
                    if (cnt == '0) begin
                        state <= ST_ISR;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_ISR: begin
                    o_busy <= 1'b1;
                    if (i_rti) begin
                        state           <= ST_RESTORE;
                        o_restore_flags <= 1'b1;
                    end
                end
                ST_RESTORE: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller with PUSH_CYCLES=2.
module tb_interrupt_controller;
    import interrupt_controller_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_int_req;
    logic       i_branch_decision;
    logic       i_push_pc;
    logic       i_pop_pc;
    logic       i_rti;
    logic       o_interrupt;
    logic       o_flush_f_d;
    logic       o_save_flags;
    logic       o_restore_flags;
    logic       o_busy;
    logic [7:0] o_int_count;

    int n_cmp = 0;
    int n_err = 0;

    interrupt_controller #(.PUSH_CYCLES(2)) dut (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_int_req         (i_int_req),
        .i_branch_decision (i_branch_decision),
        .i_push_pc         (i_push_pc),
        .i_pop_pc          (i_pop_pc),
        .i_rti             (i_rti),
        .o_interrupt       (o_interrupt),
        .o_flush_f_d       (o_flush_f_d),
        .o_save_flags      (o_save_flags),
        .o_restore_flags   (o_restore_flags),
        .o_busy            (o_busy),
        .o_int_count       (o_int_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packs the 1-bit outputs {int, flush, save, restore, busy} for compact checks
    function automatic logic [7:0] outs();
        return {3'b000, o_interrupt, o_flush_f_d, o_save_flags, o_restore_flags, o_busy};
    endfunction

    function automatic logic [7:0] st();
        return 8'(dut.state);
    endfunction

    // Full service with a safe pipeline: E0 edge, INJECT, 2 PUSH, ISR, RTI, RESTORE, IDLE
    task automatic service();
        i_int_req = 1'b1; tick();
        i_int_req = 1'b0; tick();
        tick(); tick(); tick();
        i_rti = 1'b1; tick();
        i_rti = 1'b0; tick();
    endtask

    initial begin
        i_reset = 1'b1; i_int_req = 1'b0; i_branch_decision = 1'b0;
        i_push_pc = 1'b0; i_pop_pc = 1'b0; i_rti = 1'b0;
        tick();
        check("reset_outs", outs(), 8'h00);
        check("reset_count", o_int_count, 8'd0);
        check("reset_state", st(), 8'(ST_IDLE));
        i_reset = 1'b0;
        tick();

        // Spurious RTI while idle
        i_rti = 1'b1; tick();
        check("rti_idle_state", st(), 8'(ST_IDLE));
        check("rti_idle_outs", outs(), 8'h00);
        i_rti = 1'b0;

        // Single request
        i_int_req = 1'b1; tick();
        check("single_e0_outs", outs(), 8'h00);
        check("single_e0_pend", 8'(dut.pending), 8'd1);
        i_int_req = 1'b0; tick();
        check("single_e1_outs", outs(), 8'b11001);
        check("single_e1_pend", 8'(dut.pending), 8'd0);
        tick();
        check("single_e2_outs", outs(), 8'b00101);
        check("single_e2_count", o_int_count, 8'd1);
        check("single_e2_state", st(), 8'(ST_PUSH));
        tick();
        check("single_e3_outs", outs(), 8'b00001);
        check("single_e3_state", st(), 8'(ST_PUSH));
        tick();
        check("single_e4_state", st(), 8'(ST_ISR));
        check("single_e4_outs", outs(), 8'b00001);
        i_rti = 1'b1; tick();
        check("single_restore_outs", outs(), 8'b00011);
        check("single_restore_state", st(), 8'(ST_RESTORE));
        i_rti = 1'b0; tick();
        check("single_idle_outs", outs(), 8'h00);
        check("single_idle_state", st(), 8'(ST_IDLE));

        // Unsafe hold-off: branch taken for three cycles around the request
        i_branch_decision = 1'b1; tick();
        i_int_req = 1'b1; tick();
        check("unsafe_e0_pend", 8'(dut.pending), 8'd1);
        i_int_req = 1'b0; tick();
        check("unsafe_e1_outs", outs(), 8'h00);
        check("unsafe_e1_pend", 8'(dut.pending), 8'd1);
        i_branch_decision = 1'b0; tick();
        check("unsafe_e2_outs", outs(), 8'b11001);
        tick();
        check("unsafe_count", o_int_count, 8'd2);
        // Spurious RTI during PUSH
        i_rti = 1'b1; tick();
        check("rti_push_state", st(), 8'(ST_PUSH));
        check("rti_push_outs", outs(), 8'b00001);
        i_rti = 1'b0; tick();
        check("unsafe_isr_state", st(), 8'(ST_ISR));

        // Masking: two edges inside the ISR collapse into one extra service
        i_int_req = 1'b1; tick();
        i_int_req = 1'b0; tick();
        i_int_req = 1'b1; tick();
        i_int_req = 1'b0; tick();
        check("mask_state", st(), 8'(ST_ISR));
        check("mask_outs", outs(), 8'b00001);
        check("mask_pend", 8'(dut.pending), 8'd1);
        i_rti = 1'b1; tick();
        check("mask_restore_outs", outs(), 8'b00011);
        i_rti = 1'b0; tick();
        check("mask_gap_outs", outs(), 8'h00);
        check("mask_gap_state", st(), 8'(ST_IDLE));
        tick();
        check("mask_inject_outs", outs(), 8'b11001);
        tick();
        check("mask_count", o_int_count, 8'd3);
        tick(); tick();
        check("mask_isr2_state", st(), 8'(ST_ISR));
        i_rti = 1'b1; tick();
        i_rti = 1'b0; tick(); tick(); tick();
        check("mask_no_third_outs", outs(), 8'h00);
        check("mask_no_third_count", o_int_count, 8'd3);

        // Asynchronous reset in the first PUSH cycle, request level held high
        i_int_req = 1'b1; tick();
        i_int_req = 1'b0; tick(); tick();
        check("rst_pre_save", outs(), 8'b00101);
        i_int_req = 1'b1;
        #2 i_reset = 1'b1;
        #1;
        check("rst_async_outs", outs(), 8'h00);
        check("rst_async_count", o_int_count, 8'd0);
        check("rst_async_state", st(), 8'(ST_IDLE));
        check("rst_async_pend", 8'(dut.pending), 8'd0);
        tick();
        check("rst_hold_outs", outs(), 8'h00);
        i_reset = 1'b0; tick();
        check("rst_level_pend", 8'(dut.pending), 8'd1);
        i_int_req = 1'b0; tick();
        check("rst_level_inject", outs(), 8'b11001);
        tick(); tick(); tick();
        i_rti = 1'b1; tick();
        i_rti = 1'b0; tick();
        check("rst_level_count", o_int_count, 8'd1);

        // Wrap: 255 more services bring the count from 1 back to 0
        for (int i = 0; i < 254; i++) service();
        check("wrap_255", o_int_count, 8'd255);
        service();
        check("wrap_0", o_int_count, 8'd0);
        check("wrap_idle", st(), 8'(ST_IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
